// File: rtl/seq_scan_pkg.sv
// ---------------------------------------------------------------------------
// seq_scan_pkg
// Shared types and constants for the 1001 word scanner.
//   state_t      : controller FSM state (IDLE=0, SHIFT=1, DRAIN=2, DONE=3)
//   det_state_t  : 1001 recogniser state (S0, S1, S10, S100)
//   PATTERN      : the searched bit pattern, MSB first
//   det_next()   : recogniser transition function
// ---------------------------------------------------------------------------
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Each state names the longest suffix of the input that is a prefix of 1001.
  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S100 = 2'd3
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1001;

  function automatic det_state_t det_next(input det_state_t s, input logic b);
    case (s)
      S0:      return b ? S1 : S0;
      S1:      return b ? S1 : S10;
      S10:     return b ? S1 : S100;
      // From S100 a 1 completes a match; that 1 is also the first bit of the
      // next overlapping pattern, hence S1.
      default: return b ? S1 : S0;
    endcase
  endfunction

endpackage

// File: rtl/seq_det_1001.sv
// ---------------------------------------------------------------------------
// seq_det_1001
// Moore recogniser for the bit pattern 1001 with overlap. The hit flag is
// registered: it is high for the cycle after the final 1 is sampled.
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset (state S0, hit 0)
//   clr    : synchronous clear (state S0, hit 0)
//   en     : sample bit_in this cycle
//   bit_in : serial input bit
//   hit    : registered match flag
// ---------------------------------------------------------------------------
module seq_det_1001
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic hit
);

  det_state_t state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S0;
      hit   <= 1'b0;
    end else if (clr) begin
      state <= S0;
      hit   <= 1'b0;
    end else begin
      // The flag only reflects a bit sampled this cycle; with en low it drops.
      hit <= en && (state == S100) && (bit_in == PATTERN[0]);
      if (en) state <= det_next(state, bit_in);
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seq_scan_ctrl
// Accepts a W-bit word, shifts it MSB first through a 1001 recogniser and
// reports how many matches it contained (saturating at 2^CNT_W-1).
// Optional feature: define SEQ_SCAN_CARRY_EN to keep recogniser state across
// words (stream mode); otherwise the recogniser is cleared on every accept.
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   in_valid  : word offered           in_data   : word to scan (W bits)
//   in_ready  : word can be accepted   (high only in IDLE)
//   out_valid : result valid           out_count : match count (CNT_W bits)
//   out_hit   : out_count != 0         out_ready : consumer takes the result
//   busy      : controller not in IDLE
// ---------------------------------------------------------------------------
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  input  logic             out_ready,
  output logic             busy
);

  localparam int              BC_W     = $clog2(W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [W-1:0]     sr;
  logic [BC_W-1:0]  bit_cnt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             accept;
  logic             det_clr;
  logic             det_hit;
  logic             count_inc;

  assign accept = in_valid && in_ready;

`ifdef SEQ_SCAN_CARRY_EN
  assign det_clr = 1'b0;
`else
  assign det_clr = accept;
`endif

  seq_det_1001 u_det (
    .clk    (clk),
    .reset  (reset),
    .clr    (det_clr),
    .en     (state == SHIFT),
    .bit_in (sr[W-1]),
    .hit    (det_hit)
  );

  // During the first SHIFT cycle the flag still belongs to whatever preceded
  // the word; the flag for the final bit arrives in DRAIN.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_inc  = det_hit && (((state == SHIFT) && (bit_cnt != '0)) || (state == DRAIN));
    count_next = count;
    if (count_inc && (count != CNT_MAX)) count_next = count + 1'b1;
  end

  // NOTE: all registers here are flops with async reset, written with <= only
  // so every right-hand side sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_count <= '0;
      out_hit   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sr       <= in_data;
            count    <= '0;
            bit_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr      <= {sr[W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          count   <= count_next;
          if (bit_cnt == LAST_BIT) state <= DRAIN;
        end
        DRAIN: begin
          count     <= count_next;
          out_valid <= 1'b1;
          out_count <= count_next;
          out_hit   <= (count_next != '0);
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_hit   <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_scan_ctrl
// Two instances share all inputs: dut (W=8, CNT_W=4) and dut_sat (W=8,
// CNT_W=1). Expected counts come from a 4-bit sliding window model and are
// queued at each accept; a negedge monitor pops and compares on every
// out_valid && out_ready handshake.
// ---------------------------------------------------------------------------
module tb_seq_scan_ctrl;

  localparam int W      = 8;
  localparam int PERIOD = 10;

`ifdef SEQ_SCAN_CARRY_EN
  localparam int BOUNDARY_EXP = 1;
`else
  localparam int BOUNDARY_EXP = 0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;

  logic         in_ready, out_valid, out_hit, busy;
  logic [3:0]   out_count;
  logic         s_in_ready, s_out_valid, s_out_hit, s_busy;
  logic [0:0]   s_out_count;

  typedef struct {
    int unsigned  cnt4;
    int unsigned  cnt1;
    logic [W-1:0] word;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [3:0] win = '0;
  int         checks = 0;
  int         errors = 0;

  always #(PERIOD/2) clk = ~clk;

  seq_scan_ctrl #(.W(W), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_count(out_count),
    .out_hit(out_hit), .out_ready(out_ready), .busy(busy)
  );

  seq_scan_ctrl #(.W(W), .CNT_W(1)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_count(s_out_count),
    .out_hit(s_out_hit), .out_ready(out_ready), .busy(s_busy)
  );

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Result monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got count=%0d, expected no result", out_count);
        end else begin
          mon_e = sb.pop_front();
          if (out_count !== 4'(mon_e.cnt4) || out_hit !== (mon_e.cnt4 != 0)) begin
            errors++;
            $display("FAIL result word=%b: got count=%0d hit=%b, expected count=%0d hit=%b",
                     mon_e.word, out_count, out_hit, mon_e.cnt4, mon_e.cnt4 != 0);
          end
          checks++;
          if (s_out_valid !== 1'b1 || s_out_count !== 1'(mon_e.cnt1) || s_out_hit !== (mon_e.cnt1 != 0)) begin
            errors++;
            $display("FAIL sat_result word=%b: got valid=%b count=%0d hit=%b, expected valid=1 count=%0d hit=%b",
                     mon_e.word, s_out_valid, s_out_count, s_out_hit, mon_e.cnt1, mon_e.cnt1 != 0);
          end
        end
      end else if (!out_valid) begin
        checks++;
        if (out_count !== '0 || out_hit !== 1'b0 || s_out_count !== '0 || s_out_hit !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: got count=%0d hit=%b sat_count=%0d sat_hit=%b, expected all 0",
                   out_count, out_hit, s_out_count, s_out_hit);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sliding-window reference: a match is any position where the last four
  // bits seen equal 1001.
  task automatic push_expected(input logic [W-1:0] d);
    int n = 0;
`ifndef SEQ_SCAN_CARRY_EN
    win = '0;
`endif
    for (int i = W - 1; i >= 0; i--) begin
      win = {win[2:0], d[i]};
      if (win == 4'b1001) n++;
    end
    sb.push_back('{cnt4: (n > 15) ? 15 : n, cnt1: (n > 1) ? 1 : n, word: d});
  endtask

  // Offers d until accepted; returns with time just after the accept edge.
  task automatic accept(input logic [W-1:0] d, output time t);
    logic rdy;
    int   n = 0;
    in_data  = d;
    in_valid = 1'b1;
    do begin
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 200);
    t = $time;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end else begin
      push_expected(d);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%b, expected 1", out_valid);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid || busy) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d busy=%b, expected 0 and 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== '0 || out_hit !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got rdy=%b vld=%b cnt=%0d hit=%b busy=%b, expected 1 0 0 0 0",
               in_ready, out_valid, out_count, out_hit, busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || s_in_ready !== 1'b1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b busy=%b srdy=%b sbusy=%b, expected 1 0 0 1 0",
               in_ready, out_valid, busy, s_in_ready, s_busy);
    end
  endtask

  task automatic test_single_match();
    time t;
    int  lat = 0;
    out_ready = 1'b1;
    accept(8'b1001_0000, t);
    in_valid = 1'b0;
    in_data  = 8'hFF;  // must not disturb the word in flight
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL shift_flags: got busy=%b rdy=%b, expected 1 0", busy, in_ready);
    end
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    // out_valid rises after edge W+1, so the consumer samples it at edge W+2.
    checks++;
    if (lat != W + 1) begin
      errors++;
      $display("FAIL latency: got out_valid after %0d edges, expected %0d", lat, W + 1);
    end
    checks++;
    if (out_count !== 4'd1 || out_hit !== 1'b1) begin
      errors++;
      $display("FAIL single_match: got count=%0d hit=%b, expected 1 1", out_count, out_hit);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL return_idle: got vld=%b rdy=%b busy=%b, expected 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_patterns();
    logic [W-1:0] words[$] = '{8'b1001_1001, 8'b1001_0010, 8'h00, 8'hFF, 8'b0100_1001};
    time t;
    for (int i = 0; i < 6; i++) words.push_back(W'($urandom));
    foreach (words[i]) begin
      accept(words[i], t);
      in_valid = 1'b0;
      in_data  = W'($urandom);
      wait_drain();
    end
  endtask

  task automatic test_boundary();
    time t;
    accept(8'b0000_0100, t);
    in_valid = 1'b0;
    wait_drain();
    accept(8'b1000_0000, t);
    in_valid = 1'b0;
    wait_valid();
    checks++;
    if (out_count !== 4'(BOUNDARY_EXP)) begin
      errors++;
      $display("FAIL boundary: got count=%0d, expected %0d", out_count, BOUNDARY_EXP);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[4] = '{8'b1001_0010, 8'b0010_0100, 8'b1001_1001, 8'b0110_1001};
    time t_prev, t;
    out_ready = 1'b1;
    accept(words[0], t_prev);
    for (int i = 1; i < 4; i++) begin
      accept(words[i], t);
      checks++;
      if (t - t_prev != (W + 3) * PERIOD) begin
        errors++;
        $display("FAIL throughput: got %0t between accepts, expected %0d", t - t_prev, (W + 3) * PERIOD);
      end
      t_prev = t;
    end
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_backpressure();
    time        t;
    logic [3:0] cnt0;
    logic       hit0;
    out_ready = 1'b0;
    accept(8'b1001_0010, t);
    in_valid = 1'b0;
    wait_valid();
    cnt0 = out_count;
    hit0 = out_hit;
    in_valid = 1'b1;
    in_data  = 8'b1001_1001;
    repeat (5) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_count !== cnt0 || out_hit !== hit0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure: got vld=%b cnt=%0d hit=%b rdy=%b busy=%b, expected 1 %0d %b 0 1",
                 out_valid, out_count, out_hit, in_ready, busy, cnt0, hit0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_accept_in_done: got busy=%b vld=%b, expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    time t;
    out_ready = 1'b1;
    accept(8'b0100_1111, t);  // leaves the recogniser in S100 after four bits
    in_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    sb.delete();
    win = '0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_count !== '0) begin
      errors++;
      $display("FAIL reset_mid_shift: got rdy=%b vld=%b busy=%b cnt=%0d, expected 1 0 0 0",
               in_ready, out_valid, busy, out_count);
    end
    tick();
    reset = 1'b0;
    tick();
    accept(8'b1000_0000, t);
    in_valid = 1'b0;
    wait_drain();
    accept(8'b0001_0010, t);
    in_valid = 1'b0;
    wait_valid();
    checks++;
    if (out_count !== 4'd1 || out_hit !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: got count=%0d hit=%b, expected 1 1", out_count, out_hit);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_patterns();
    test_boundary();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_shift();
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending results, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
